// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module : wb_port_arbiter_pkg
// Brief  : Shared types, active-list sizing and wrap-distance helper for the
//          write-back port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package wb_port_arbiter_pkg;

    localparam int AL_SIZE  = `AL_SIZE;
    localparam int AL_IDX_W = $clog2(AL_SIZE);
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [AL_IDX_W-1:0] al_idx;
        logic [XLEN-1:0]     data;
        logic [4:0]          rd;
        logic                uses_rd;
    } wb_req_t;

    // Distance from b forward to a around the active list, i.e. (a - b) mod AL_SIZE.
    function automatic logic [AL_IDX_W-1:0] al_dist(input logic [AL_IDX_W-1:0] a,
                                                    input logic [AL_IDX_W-1:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = d + AL_SIZE;
        return AL_IDX_W'(d);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module : wb_port_arbiter_if
// Brief  : Write-back port bundle: one valid/al_idx/data/rd/uses_rd lane per port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    import wb_port_arbiter_pkg::*;

    logic [NUM_PORTS-1:0]                valid;
    logic [NUM_PORTS-1:0][AL_IDX_W-1:0]  al_idx;
    logic [NUM_PORTS-1:0][XLEN-1:0]      data;
    logic [NUM_PORTS-1:0][4:0]           rd;
    logic [NUM_PORTS-1:0]                uses_rd;

    modport master (output valid, al_idx, data, rd, uses_rd);
    modport slave  (input  valid, al_idx, data, rd, uses_rd);

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_multi_picker.sv
// ============================================================================
// Module : wb_multi_picker
// Brief  : Picks up to NUM_PORTS eligible sources by ascending key (ties to the
//          lower index); the k-th winner is reported on port k.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_multi_picker #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4,
    parameter int KEY_W     = 3,
    parameter int IDX_W     = 3
) (
    input  wire  [NUM_REQ-1:0]              eligible,
    input  wire  [NUM_REQ-1:0][KEY_W-1:0]   key,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [NUM_PORTS-1:0][IDX_W-1:0] port_idx,
    output logic [IDX_W-1:0]                last_idx
);

    localparam int RANK_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0][RANK_W-1:0] w_rank;

    // Rank = number of eligible sources that beat this one; rank k wins port k.
    always_comb begin
        w_rank = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j != i) && eligible[j] &&
                    ((key[j] < key[i]) || ((key[j] == key[i]) && (j < i)))) begin
                    w_rank[i] = w_rank[i] + RANK_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant      = '0;
        port_valid = '0;
        port_idx   = '0;
        last_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (eligible[i] && (w_rank[i] == RANK_W'(k))) begin
                    grant[i]      = 1'b1;
                    port_valid[k] = 1'b1;
                    port_idx[k]   = IDX_W'(i);
                end
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_valid[k]) last_idx = port_idx[k];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Shares NUM_PORTS write-back ports among NUM_REQ result sources with
//          per-source hold registers and recall squashing. Define
//          WB_ARB_AGE_PRIO_EN for oldest-first priority instead of round-robin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 4
) (
    input  wire                               clk,
    input  wire                               rst_n,
    input  wire                               if_recall,
    input  wire  [AL_IDX_W-1:0]               new_front,
    input  wire  [AL_IDX_W-1:0]               old_front,
    input  wire  [AL_IDX_W-1:0]               back,
    input  wire  [NUM_REQ-1:0]                i_req_valid,
    output logic [NUM_REQ-1:0]                o_req_ready,
    input  wire  [NUM_REQ-1:0][AL_IDX_W-1:0]  i_req_al_idx,
    input  wire  [NUM_REQ-1:0][XLEN-1:0]      i_req_data,
    input  wire  [NUM_REQ-1:0][4:0]           i_req_rd,
    input  wire  [NUM_REQ-1:0]                i_req_uses_rd,
    wb_port_arbiter_if.master                 o_wb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic squashed(input logic                recall,
                                      input logic [AL_IDX_W-1:0] idx,
                                      input logic [AL_IDX_W-1:0] nf,
                                      input logic [AL_IDX_W-1:0] of);
        return recall && (al_dist(idx, nf) < al_dist(of, nf));
    endfunction

    wb_req_t [NUM_REQ-1:0]          r_hold;
    logic    [NUM_REQ-1:0]          r_hold_valid;
    logic    [NUM_REQ-1:0]          w_sq_hold;
    logic    [NUM_REQ-1:0]          w_sq_in;
    logic    [NUM_REQ-1:0]          w_eligible;
    logic    [NUM_REQ-1:0]          w_grant;
    logic    [NUM_REQ-1:0]          w_accept;
    logic    [NUM_PORTS-1:0]        w_port_valid;
    logic    [NUM_PORTS-1:0][IDX_W-1:0] w_port_idx;
    logic    [IDX_W-1:0]            w_last_idx;

    always_comb begin
        w_sq_hold = '0;
        w_sq_in   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sq_hold[i] = squashed(if_recall, r_hold[i].al_idx, new_front, old_front);
            w_sq_in[i]   = squashed(if_recall, i_req_al_idx[i], new_front, old_front);
        end
    end

    assign w_eligible  = r_hold_valid & ~w_sq_hold;
    assign o_req_ready = ~r_hold_valid | w_grant | w_sq_hold;
    assign w_accept    = i_req_valid & o_req_ready;

`ifdef WB_ARB_AGE_PRIO_EN
    localparam int KEY_W = AL_IDX_W;
    logic [NUM_REQ-1:0][KEY_W-1:0] w_key;
    logic                          unused_last;

    always_comb begin
        w_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_key[i] = al_dist(r_hold[i].al_idx, back);
        end
    end

    assign unused_last = ^w_last_idx;
`else
    localparam int KEY_W = IDX_W;
    logic [NUM_REQ-1:0][KEY_W-1:0] w_key;
    logic [IDX_W-1:0]              r_rr_ptr;
    logic                          unused_back;

    // Key is the distance of each source above the round-robin pointer.
    always_comb begin
        w_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int d;
            d = i - int'(r_rr_ptr);
            if (d < 0) d = d + NUM_REQ;
            w_key[i] = KEY_W'(d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (|w_grant) begin
            r_rr_ptr <= (w_last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_last_idx + IDX_W'(1);
        end
    end

    assign unused_back = ^back;
`endif

    wb_multi_picker #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .KEY_W     (KEY_W),
        .IDX_W     (IDX_W)
    ) u_picker (
        .eligible   (w_eligible),
        .key        (w_key),
        .grant      (w_grant),
        .port_valid (w_port_valid),
        .port_idx   (w_port_idx),
        .last_idx   (w_last_idx)
    );

    // A same-cycle accept wins over the clear from a grant or squash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= '0;
            r_hold       <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_hold_valid[i] <= ~w_sq_in[i];
                    r_hold[i]       <= '{al_idx:  i_req_al_idx[i],
                                         data:    i_req_data[i],
                                         rd:      i_req_rd[i],
                                         uses_rd: i_req_uses_rd[i]};
                end else if (w_grant[i] || w_sq_hold[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    logic [NUM_PORTS-1:0]                r_wb_valid;
    logic [NUM_PORTS-1:0][AL_IDX_W-1:0]  r_wb_al_idx;
    logic [NUM_PORTS-1:0][XLEN-1:0]      r_wb_data;
    logic [NUM_PORTS-1:0][4:0]           r_wb_rd;
    logic [NUM_PORTS-1:0]                r_wb_uses_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= '0;
            r_wb_al_idx  <= '0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_uses_rd <= '0;
        end else begin
            r_wb_valid <= w_port_valid;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (w_port_valid[k]) begin
                    r_wb_al_idx[k]  <= r_hold[w_port_idx[k]].al_idx;
                    r_wb_data[k]    <= r_hold[w_port_idx[k]].data;
                    r_wb_rd[k]      <= r_hold[w_port_idx[k]].rd;
                    r_wb_uses_rd[k] <= r_hold[w_port_idx[k]].uses_rd;
                end
            end
        end
    end

    assign o_wb.valid   = r_wb_valid;
    assign o_wb.al_idx  = r_wb_al_idx;
    assign o_wb.data    = r_wb_data;
    assign o_wb.rd      = r_wb_rd;
    assign o_wb.uses_rd = r_wb_uses_rd;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module : tb_wb_port_arbiter
// Brief  : Scoreboard bench for wb_port_arbiter (round-robin or, with
//          WB_ARB_AGE_PRIO_EN, age-priority build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int NR = 6;
    localparam int NP = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        if_recall;
    logic [AL_IDX_W-1:0]         new_front, old_front, back;
    logic [NR-1:0]               req_valid;
    logic [NR-1:0]               req_ready;
    logic [NR-1:0][AL_IDX_W-1:0] req_al;
    logic [NR-1:0][XLEN-1:0]     req_data;
    logic [NR-1:0][4:0]          req_rd;
    logic [NR-1:0]               req_uses;

    wb_port_arbiter_if #(.NUM_PORTS(NP)) wb_if ();

    wb_port_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_recall     (if_recall),
        .new_front     (new_front),
        .old_front     (old_front),
        .back          (back),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_al_idx  (req_al),
        .i_req_data    (req_data),
        .i_req_rd      (req_rd),
        .i_req_uses_rd (req_uses),
        .o_wb          (wb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  port;
        logic [AL_IDX_W-1:0] al;
        logic [XLEN-1:0]     data;
        logic [4:0]          rd;
        logic                uses;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every valid port lane consumes the next expected entry in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < NP; k++) begin
                if (wb_if.valid[k]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected port=%0d al=%0d data=%h, expected no output",
                                 k, wb_if.al_idx[k], wb_if.data[k]);
                    end else begin
                        e = sb.pop_front();
                        if (e.port != k || wb_if.al_idx[k] !== e.al || wb_if.data[k] !== e.data ||
                            wb_if.rd[k] !== e.rd || wb_if.uses_rd[k] !== e.uses) begin
                            errors++;
                            $display("FAIL wb_payload got port=%0d al=%0d data=%h rd=%0d uses=%0b, expected port=%0d al=%0d data=%h rd=%0d uses=%0b",
                                     k, wb_if.al_idx[k], wb_if.data[k], wb_if.rd[k], wb_if.uses_rd[k],
                                     e.port, e.al, e.data, e.rd, e.uses);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(int i, int al, logic [XLEN-1:0] d, int rd, int u);
        req_valid[i] = 1'b1;
        req_al[i]    = AL_IDX_W'(al);
        req_data[i]  = d;
        req_rd[i]    = 5'(rd);
        req_uses[i]  = u[0];
    endtask

    task automatic expect_wb(int port, int al, logic [XLEN-1:0] d, int rd, int u);
        exp_t e;
        e.port = port;
        e.al   = AL_IDX_W'(al);
        e.data = d;
        e.rd   = 5'(rd);
        e.uses = u[0];
        sb.push_back(e);
    endtask

    task automatic check_ready(logic [NR-1:0] exp, string name);
        checks++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL %s ready got %b, expected %b", name, req_ready, exp);
        end
    endtask

    task automatic check_idle(string name);
        checks++;
        if (wb_if.valid !== '0) begin
            errors++;
            $display("FAIL %s wb_valid got %b, expected 0000", name, wb_if.valid);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        if_recall = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_idle("reset_valid");
        check_ready(6'h3F, "reset_ready");
    endtask

    initial begin
        rst_n = 1'b0; if_recall = 1'b0; new_front = '0; old_front = '0; back = AL_IDX_W'(30);
        req_valid = '0; req_al = '0; req_data = '0; req_rd = '0; req_uses = '0;
        #1 check_idle("reset_initial");
        do_reset();

        // Single source, two edges to port 0.
        set_src(2, 5, 32'hDEADBEEF, 7, 1);
        expect_wb(0, 5, 32'hDEADBEEF, 7, 1);
        tick();
        req_valid = '0;
        repeat (3) tick();

`ifndef WB_ARB_AGE_PRIO_EN
        // Oversubscription: A grants 0-3, then 4,5 plus B0,B1, then B2,B3.
        do_reset();
        for (int i = 0; i < NR; i++) set_src(i, i, 32'hA000_0000 + i, i + 1, i & 1);
        for (int i = 0; i < 4; i++) expect_wb(i, i, 32'hA000_0000 + i, i + 1, i & 1);
        expect_wb(0, 4, 32'hA000_0004, 5, 0);
        expect_wb(1, 5, 32'hA000_0005, 6, 1);
        expect_wb(2, 8, 32'hB000_0000, 10, 0);
        expect_wb(3, 9, 32'hB000_0001, 11, 1);
        expect_wb(0, 10, 32'hB000_0002, 12, 0);
        expect_wb(1, 11, 32'hB000_0003, 13, 1);
        tick();
        for (int i = 0; i < NR; i++) set_src(i, 8 + i, 32'hB000_0000 + i, 10 + i, i & 1);
        #1 check_ready(6'h0F, "oversub_c1");
        tick();
        req_valid = '0;
        #1 check_ready(6'h33, "oversub_c2");
        repeat (4) tick();
`endif

        // Recall with wrap: al 31 and 1 squashed, 2 and 29 granted; incoming al 0 discarded.
        do_reset();
        set_src(0, 31, 32'h3100_0000, 1, 1);
        set_src(1, 1,  32'h0100_0000, 2, 1);
        set_src(2, 2,  32'h0200_0000, 3, 0);
        set_src(3, 29, 32'h2900_0000, 4, 1);
        expect_wb(0, 2,  32'h0200_0000, 3, 0);
        expect_wb(1, 29, 32'h2900_0000, 4, 1);
        expect_wb(0, 5,  32'h0500_0000, 6, 1);
        tick();
        req_valid = '0;
        if_recall = 1'b1; new_front = AL_IDX_W'(30); old_front = AL_IDX_W'(2);
        set_src(4, 0, 32'h0000_0000, 5, 1);
        set_src(5, 5, 32'h0500_0000, 6, 1);
        #1 check_ready(6'h3F, "recall_wrap_ready");
        tick();
        if_recall = 1'b0; req_valid = '0;
        repeat (3) tick();

        // Recall with an empty range squashes nothing.
        do_reset();
        set_src(0, 31, 32'h3100_0000, 1, 1);
        set_src(1, 1,  32'h0100_0000, 2, 1);
        set_src(2, 2,  32'h0200_0000, 3, 0);
        set_src(3, 29, 32'h2900_0000, 4, 1);
        expect_wb(0, 31, 32'h3100_0000, 1, 1);
        expect_wb(1, 1,  32'h0100_0000, 2, 1);
        expect_wb(2, 2,  32'h0200_0000, 3, 0);
        expect_wb(3, 29, 32'h2900_0000, 4, 1);
        expect_wb(0, 0,  32'h0000_0000, 5, 1);
        expect_wb(1, 5,  32'h0500_0000, 6, 1);
        tick();
        req_valid = '0;
        if_recall = 1'b1; new_front = AL_IDX_W'(30); old_front = AL_IDX_W'(30);
        set_src(4, 0, 32'h0000_0000, 5, 1);
        set_src(5, 5, 32'h0500_0000, 6, 1);
        #1 check_ready(6'h3F, "recall_empty_ready");
        tick();
        if_recall = 1'b0; req_valid = '0;
        repeat (3) tick();

`ifdef WB_ARB_AGE_PRIO_EN
        // Oldest first from back=10.
        do_reset();
        back = AL_IDX_W'(10);
        set_src(0, 9,  32'hC000_0000, 0, 0);
        set_src(1, 11, 32'hC000_0001, 1, 0);
        set_src(2, 12, 32'hC000_0002, 2, 0);
        set_src(3, 20, 32'hC000_0003, 3, 0);
        set_src(4, 13, 32'hC000_0004, 4, 0);
        set_src(5, 10, 32'hC000_0005, 5, 0);
        expect_wb(0, 10, 32'hC000_0005, 5, 0);
        expect_wb(1, 11, 32'hC000_0001, 1, 0);
        expect_wb(2, 12, 32'hC000_0002, 2, 0);
        expect_wb(3, 13, 32'hC000_0004, 4, 0);
        expect_wb(0, 20, 32'hC000_0003, 3, 0);
        expect_wb(1, 9,  32'hC000_0000, 0, 0);
        tick();
        req_valid = '0;
        repeat (4) tick();
        back = AL_IDX_W'(30);
`endif

        // Reset mid-traffic: first four delivered, held 4 and 5 must vanish.
        do_reset();
        for (int i = 0; i < NR; i++) set_src(i, 16 + i, 32'h5000_0000 + i, 20 + i, 1);
        for (int i = 0; i < 4; i++) expect_wb(i, 16 + i, 32'h5000_0000 + i, 20 + i, 1);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle("reset_async_valid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_ready(6'h3F, "reset_release_ready");
        check_idle("reset_release_valid");
        repeat (4) tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending got %0d, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
